// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: walks the CSR read/write sequence for exceptions,
// interrupts and MRET, then issues a one-cycle fetch redirect.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    output logic            trap_ready,
    input  logic            irq_ext,
    input  logic            irq_sw,
    input  logic            irq_tmr,
    input  logic [XLEN-1:0] int_pc,
    input  logic            int_pc_valid,
    output logic            csr_rd_en,
    output logic            csr_wb_en,
    output logic [11:0]     csr_idx,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [3:0] {
        IDLE, RD_STAT, RD_MIE, WR_EPC, WR_CAUSE, WR_TVAL, WR_STAT, RD_TVEC, RD_EPC, REDIR
    } state_e;

    typedef enum logic [1:0] {K_EXC, K_INT, K_MRET} kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [2:0]      irq_q, irq_d;
    logic [4:0]      code_q, code_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;

    logic            csr_rd_en_q, csr_rd_en_d;
    logic            csr_wb_en_q, csr_wb_en_d;
    logic [11:0]     csr_idx_q, csr_idx_d;
    logic [XLEN-1:0] csr_wdata_q, csr_wdata_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [2:0]      pend;
    logic [XLEN-1:0] target;

    function automatic logic [XLEN-1:0] trapStatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mretStatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        pc_d             = pc_q;
        tval_d           = tval_q;
        irq_d            = irq_q;
        code_d           = code_q;
        mstatus_d        = mstatus_q;
        csr_rd_en_d      = 1'b0;
        csr_wb_en_d      = 1'b0;
        csr_idx_d        = '0;
        csr_wdata_d      = '0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        pend             = '0;
        target           = '0;

        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    kind_d  = K_EXC;
                    pc_d    = exc_pc;
                    tval_d  = exc_tval;
                    code_d  = exc_code;
                    irq_d   = {irq_ext, irq_sw, irq_tmr};
                    state_d = RD_STAT;
                end else if (mret_valid) begin
                    kind_d  = K_MRET;
                    pc_d    = exc_pc;
                    tval_d  = '0;
                    code_d  = '0;
                    irq_d   = {irq_ext, irq_sw, irq_tmr};
                    state_d = RD_STAT;
                end else if (int_pc_valid && (irq_ext || irq_sw || irq_tmr)) begin
                    kind_d  = K_INT;
                    pc_d    = int_pc;
                    tval_d  = '0;
                    code_d  = '0;
                    irq_d   = {irq_ext, irq_sw, irq_tmr};
                    state_d = RD_STAT;
                end
            end
            RD_STAT: begin
                mstatus_d = csr_rdata;
                case (kind_q)
                    K_INT:   state_d = RD_MIE;
                    K_MRET:  state_d = WR_STAT;
                    default: state_d = WR_EPC;
                endcase
            end
            RD_MIE: begin
                // Latched vector {ext,sw,tmr} masked by the matching mie enable bits.
                pend = irq_q & {csr_rdata[11], csr_rdata[3], csr_rdata[7]};
                if (mstatus_q[3] && (pend != 3'b000)) begin
                    code_d  = pend[2] ? 5'd11 : (pend[1] ? 5'd3 : 5'd7);
                    state_d = WR_EPC;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_EPC:   state_d = WR_CAUSE;
            WR_CAUSE: state_d = WR_TVAL;
            WR_TVAL:  state_d = WR_STAT;
            WR_STAT:  state_d = (kind_q == K_MRET) ? RD_EPC : RD_TVEC;
            RD_TVEC: begin
                target = csr_rdata & ALIGN_MASK;
                if ((csr_rdata[1:0] == 2'b01) && (kind_q == K_INT)) begin
                    target = target + {{(XLEN-7){1'b0}}, code_q, 2'b00};
                end
                state_d = REDIR;
            end
            RD_EPC: begin
                target  = csr_rdata & ALIGN_MASK;
                state_d = REDIR;
            end
            REDIR:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            RD_STAT: begin csr_rd_en_d = 1'b1; csr_idx_d = CSR_MSTATUS; end
            RD_MIE:  begin csr_rd_en_d = 1'b1; csr_idx_d = CSR_MIE;     end
            RD_TVEC: begin csr_rd_en_d = 1'b1; csr_idx_d = CSR_MTVEC;   end
            RD_EPC:  begin csr_rd_en_d = 1'b1; csr_idx_d = CSR_MEPC;    end
            WR_EPC: begin
                csr_wb_en_d = 1'b1;
                csr_idx_d   = CSR_MEPC;
                csr_wdata_d = pc_d & ALIGN_MASK;
            end
            WR_CAUSE: begin
                csr_wb_en_d = 1'b1;
                csr_idx_d   = CSR_MCAUSE;
                csr_wdata_d = {(kind_d == K_INT), {(XLEN-6){1'b0}}, code_d};
            end
            WR_TVAL: begin
                csr_wb_en_d = 1'b1;
                csr_idx_d   = CSR_MTVAL;
                csr_wdata_d = (kind_d == K_INT) ? '0 : tval_d;
            end
            WR_STAT: begin
                csr_wb_en_d = 1'b1;
                csr_idx_d   = CSR_MSTATUS;
                csr_wdata_d = (kind_d == K_MRET) ? mretStatus(mstatus_d) : trapStatus(mstatus_d);
            end
            REDIR: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            kind_q           <= K_EXC;
            pc_q             <= '0;
            tval_q           <= '0;
            irq_q            <= '0;
            code_q           <= '0;
            mstatus_q        <= '0;
            csr_rd_en_q      <= 1'b0;
            csr_wb_en_q      <= 1'b0;
            csr_idx_q        <= '0;
            csr_wdata_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            kind_q           <= kind_d;
            pc_q             <= pc_d;
            tval_q           <= tval_d;
            irq_q            <= irq_d;
            code_q           <= code_d;
            mstatus_q        <= mstatus_d;
            csr_rd_en_q      <= csr_rd_en_d;
            csr_wb_en_q      <= csr_wb_en_d;
            csr_idx_q        <= csr_idx_d;
            csr_wdata_q      <= csr_wdata_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign trap_ready     = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign csr_rd_en      = csr_rd_en_q;
    assign csr_wb_en      = csr_wb_en_q;
    assign csr_idx        = csr_idx_q;
    assign csr_wdata      = csr_wdata_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
